// File: rtl/sgbm_dp_ram.sv
// sgbm_dp_ram: simple dual-port synchronous RAM (one write port, one read
// port, single clock) holding one aggregated cost vector per image column.
// Read-during-write to the same address returns the old contents.
// Optional feature macro: DP_RAM_OUT_REG_EN adds a second output register,
// which raises read latency from 1 to 2 clocks.
// aclr clears only the read output register(s); the array keeps its contents.
module sgbm_dp_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] wraddress,
  input  logic                  wren,
  input  logic [ADDR_WIDTH-1:0] rdaddress,
  output logic [DATA_WIDTH-1:0] q
);

  localparam int unsigned DEPTH = 32'(1) << ADDR_WIDTH;

  // No reset and no asynchronous read on the array so it maps onto block RAM.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;

  // Write port: the array is untouched by aclr.
  always_ff @(posedge clk) begin
    if (wren) begin
      mem_q[wraddress] <= data;
    end
  end

  // Array read register: samples every edge, returns pre-write data on a collision.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem_q[rdaddress];
    end
  end

`ifdef DP_RAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] out_q;

  // Extra output stage for timing closure on wide cost words.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      out_q <= '0;
    end else begin
      out_q <= rd_q;
    end
  end

  assign q = out_q;
`else
  assign q = rd_q;
`endif

endmodule

// File: tb/tb_sgbm_dp_ram.sv
// Directed testbench for sgbm_dp_ram (ADDR_WIDTH=4, DATA_WIDTH=8).
// Works in both the default build and with DP_RAM_OUT_REG_EN defined.
module tb_sgbm_dp_ram;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
`ifdef DP_RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk;
  logic          aclr;
  logic [DW-1:0] data;
  logic [AW-1:0] wraddress;
  logic          wren;
  logic [AW-1:0] rdaddress;
  logic [DW-1:0] q;

  int checks;
  int failures;

  logic [AW-1:0] addr_q [$];
  logic [DW-1:0] exp_q  [$];

  sgbm_dp_ram #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk      (clk),
    .aclr     (aclr),
    .data     (data),
    .wraddress(wraddress),
    .wren     (wren),
    .rdaddress(rdaddress),
    .q        (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DW-1:0] got,
                          input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wren      = 1'b1;
    wraddress = a;
    data      = d;
    tick();
    wren      = 1'b0;
  endtask

  // Back-to-back reads from addr_q; q checked with exactly LAT clocks latency.
  task automatic run_stream(input string tag);
    int n;
    n = addr_q.size();
    for (int k = 0; k < n + LAT - 1; k++) begin
      if (k < n) rdaddress = addr_q[k];
      tick();
      if (k >= LAT - 1) check_eq(tag, q, exp_q[k-LAT+1]);
    end
    addr_q.delete();
    exp_q.delete();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    aclr      = 1'b1;
    wren      = 1'b0;
    data      = '0;
    wraddress = '0;
    rdaddress = '0;
    #3;
    check_eq("reset_q", q, 8'h00);
    tick();
    tick();
    aclr = 1'b0;

    // Basic write then read
    wr(4'd3, 8'hA5);
    addr_q.push_back(4'd3); exp_q.push_back(8'hA5);
    run_stream("basic_rd");

    // Read-during-write returns old data, new data on the following read
    wr(4'd7, 8'h11);
    rdaddress = 4'd7;
    wr(4'd7, 8'h22);
    repeat (LAT - 1) tick();
    check_eq("rdw_old", q, 8'h11);
    tick();
    check_eq("rdw_new", q, 8'h22);

    // wren gating
    wr(4'd5, 8'h55);
    wren      = 1'b0;
    wraddress = 4'd5;
    data      = 8'hFF;
    tick();
    addr_q.push_back(4'd5); exp_q.push_back(8'h55);
    run_stream("wren_gate");

    // Reset mid-stream: async clear, contents preserved, writes still land
    for (int i = 0; i < 4; i++) wr(AW'(i), DW'(i + 1));
    for (int i = 0; i < 3; i++) begin
      addr_q.push_back(AW'(i)); exp_q.push_back(DW'(i + 1));
    end
    run_stream("pre_aclr");
    rdaddress = 4'd3;
    tick();
    #2;
    aclr = 1'b1;
    #1;
    check_eq("aclr_async", q, 8'h00);
    wren      = 1'b1;
    wraddress = 4'd9;
    data      = 8'h99;
    rdaddress = 4'd0;
    tick();
    wren = 1'b0;
    check_eq("aclr_hold0", q, 8'h00);
    rdaddress = 4'd1;
    tick();
    check_eq("aclr_hold1", q, 8'h00);
    aclr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr_q.push_back(AW'(i)); exp_q.push_back(DW'(i + 1));
    end
    addr_q.push_back(4'd9); exp_q.push_back(8'h99);
    run_stream("post_aclr");

    // Address extremes back-to-back
    wr(4'd15, 8'h3C);
    wr(4'd0, 8'h0F);
    addr_q.push_back(4'd15); exp_q.push_back(8'h3C);
    addr_q.push_back(4'd0);  exp_q.push_back(8'h0F);
    run_stream("wrap");

    // Full sweep: pattern addr^0x5A, read descending
    for (int i = 0; i < DEPTH; i++) wr(AW'(i), DW'(i) ^ 8'h5A);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      addr_q.push_back(AW'(i)); exp_q.push_back(DW'(i) ^ 8'h5A);
    end
    run_stream("sweep");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
